// File: rtl/ex_bus_pkg.sv
// Shared definitions for the ex_bus data-memory responder: default widths,
// address wrap helpers and the per-port request record.
package ex_bus_pkg;

  localparam int EX_ADDR_W  = 15;
  localparam int EX_DATA_W  = 64;
  // Requests are carried zero-extended to this width so the helpers work
  // for any ADDR_W / DEPTH_LOG2 combination up to 32 bits.
  localparam int REQ_ADDR_W = 32;

  // One port request: word address (zero-extended), enable, double-word enable.
  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  en;
    logic                  x2_en;
  } ex_req_t;

  // Effective word address: bits at and above dl2 are ignored (modulo wrap).
  function automatic logic [REQ_ADDR_W-1:0] eff_addr(
    input logic [REQ_ADDR_W-1:0] a,
    input int unsigned           dl2
  );
    return a & ((REQ_ADDR_W'(1) << dl2) - REQ_ADDR_W'(1));
  endfunction

  // Address of the second word of an x2 access; the top word wraps to 0.
  function automatic logic [REQ_ADDR_W-1:0] next_addr(
    input logic [REQ_ADDR_W-1:0] a,
    input int unsigned           dl2
  );
    return eff_addr(a + REQ_ADDR_W'(1), dl2);
  endfunction

endpackage

// File: rtl/ex_bus_mem_bank.sv
// One storage bank (even or odd words). Combinational read ports so the
// top-level output registers give read-first behaviour; write port 1 wins
// when both ports write the same index on the same edge.
module ex_bus_mem_bank #(
  parameter int IDX_W  = 11,
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic [IDX_W-1:0]  rd_0_idx_i,
  input  logic [IDX_W-1:0]  rd_1_idx_i,
  output logic [DATA_W-1:0] rd_0_data_o,
  output logic [DATA_W-1:0] rd_1_data_o,
  input  logic              wr_0_en_i,
  input  logic [IDX_W-1:0]  wr_0_idx_i,
  input  logic [DATA_W-1:0] wr_0_data_i,
  input  logic              wr_1_en_i,
  input  logic [IDX_W-1:0]  wr_1_idx_i,
  input  logic [DATA_W-1:0] wr_1_data_i
);

  logic [DATA_W-1:0] mem_q [0:(1<<IDX_W)-1];

  assign rd_0_data_o = mem_q[rd_0_idx_i];
  assign rd_1_data_o = mem_q[rd_1_idx_i];

  // Storage write; port 1 is assigned last so it wins on a shared index.
  always_ff @(posedge clk_i) begin
    if (wr_0_en_i) mem_q[wr_0_idx_i] <= wr_0_data_i;
    if (wr_1_en_i) mem_q[wr_1_idx_i] <= wr_1_data_i;
  end

endmodule

// File: rtl/ex_bus_mem_responder.sv
// ex_bus data-memory responder: two read ports and two write ports, each
// with an optional double-word (x2) access, fixed one-cycle read latency.
// Storage is split into even/odd banks so an x2 access touches one word per bank.
module ex_bus_mem_responder
  import ex_bus_pkg::*;
#(
  parameter int ADDR_W     = EX_ADDR_W,
  parameter int DATA_W     = EX_DATA_W,
  parameter int DEPTH_LOG2 = 12,
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_rd_0_addr,
  input  logic              i_rd_0_en,
  input  logic              i_rd_0_x2_en,
  input  logic [ADDR_W-1:0] i_rd_1_addr,
  input  logic              i_rd_1_en,
  input  logic              i_rd_1_x2_en,
  input  logic [ADDR_W-1:0] i_wr_0_addr,
  input  logic              i_wr_0_en,
  input  logic              i_wr_0_x2_en,
  input  logic [DATA_W-1:0] i_wr_0_data,
  input  logic [DATA_W-1:0] i_wr_0_data_x2,
  input  logic [ADDR_W-1:0] i_wr_1_addr,
  input  logic              i_wr_1_en,
  input  logic              i_wr_1_x2_en,
  input  logic [DATA_W-1:0] i_wr_1_data,
  input  logic [DATA_W-1:0] i_wr_1_data_x2,
  output logic [DATA_W-1:0] o_rd_0_data,
  output logic [DATA_W-1:0] o_rd_0_data_x2,
  output logic [DATA_W-1:0] o_rd_1_data,
  output logic [DATA_W-1:0] o_rd_1_data_x2,
  output logic              o_wr_collision,
  output logic [CNT_W-1:0]  o_collision_cnt
);

  localparam int IDX_W = DEPTH_LOG2 - 1;

  ex_req_t               rd_req [2];
  ex_req_t               wr_req [2];
  logic [DATA_W-1:0]     wr_d0 [2];
  logic [DATA_W-1:0]     wr_d1 [2];
  logic [DEPTH_LOG2-1:0] rd_a [2];
  logic [DEPTH_LOG2-1:0] rd_b [2];
  logic [DEPTH_LOG2-1:0] wr_a [2];
  logic [DEPTH_LOG2-1:0] wr_b [2];
  logic [IDX_W-1:0]      ev_rd_idx [2];
  logic [IDX_W-1:0]      od_rd_idx [2];
  logic [IDX_W-1:0]      ev_wr_idx [2];
  logic [IDX_W-1:0]      od_wr_idx [2];
  logic                  ev_we [2];
  logic                  od_we [2];
  logic [DATA_W-1:0]     ev_wd [2];
  logic [DATA_W-1:0]     od_wd [2];
  logic [DATA_W-1:0]     ev_rd [2];
  logic [DATA_W-1:0]     od_rd [2];
  logic [DATA_W-1:0]     rd_w0 [2];
  logic [DATA_W-1:0]     rd_w1 [2];
  logic                  collide;

  logic [DATA_W-1:0] rd_0_data_q, rd_0_data_x2_q, rd_1_data_q, rd_1_data_x2_q;
  logic              wr_collision_q;
  logic [CNT_W-1:0]  collision_cnt_q, collision_cnt_d;

  assign rd_req[0] = '{addr: REQ_ADDR_W'(i_rd_0_addr), en: i_rd_0_en, x2_en: i_rd_0_x2_en};
  assign rd_req[1] = '{addr: REQ_ADDR_W'(i_rd_1_addr), en: i_rd_1_en, x2_en: i_rd_1_x2_en};
  assign wr_req[0] = '{addr: REQ_ADDR_W'(i_wr_0_addr), en: i_wr_0_en, x2_en: i_wr_0_x2_en};
  assign wr_req[1] = '{addr: REQ_ADDR_W'(i_wr_1_addr), en: i_wr_1_en, x2_en: i_wr_1_x2_en};
  assign wr_d0[0]  = i_wr_0_data;
  assign wr_d1[0]  = i_wr_0_data_x2;
  assign wr_d0[1]  = i_wr_1_data;
  assign wr_d1[1]  = i_wr_1_data_x2;

  // Address steering: word A (eff addr) and word B (wrapped A+1) always sit in
  // opposite banks; an odd start puts B in the even bank at index+1.
  // Writes are gated by reset so edges during reset leave memory untouched.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_a[p] = DEPTH_LOG2'(eff_addr(rd_req[p].addr, DEPTH_LOG2));
      rd_b[p] = DEPTH_LOG2'(next_addr(rd_req[p].addr, DEPTH_LOG2));
      wr_a[p] = DEPTH_LOG2'(eff_addr(wr_req[p].addr, DEPTH_LOG2));
      wr_b[p] = DEPTH_LOG2'(next_addr(wr_req[p].addr, DEPTH_LOG2));
      ev_rd_idx[p] = rd_a[p][0] ? rd_b[p][DEPTH_LOG2-1:1] : rd_a[p][DEPTH_LOG2-1:1];
      od_rd_idx[p] = rd_a[p][0] ? rd_a[p][DEPTH_LOG2-1:1] : rd_b[p][DEPTH_LOG2-1:1];
      ev_wr_idx[p] = wr_a[p][0] ? wr_b[p][DEPTH_LOG2-1:1] : wr_a[p][DEPTH_LOG2-1:1];
      od_wr_idx[p] = wr_a[p][0] ? wr_a[p][DEPTH_LOG2-1:1] : wr_b[p][DEPTH_LOG2-1:1];
      ev_we[p] = wr_req[p].en & i_rst_n & (~wr_a[p][0] | wr_req[p].x2_en);
      od_we[p] = wr_req[p].en & i_rst_n & ( wr_a[p][0] | wr_req[p].x2_en);
      ev_wd[p] = wr_a[p][0] ? wr_d1[p] : wr_d0[p];
      od_wd[p] = wr_a[p][0] ? wr_d0[p] : wr_d1[p];
    end
  end

  // Un-steer bank read data back into (word A, word B) order per port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_w0[p] = rd_a[p][0] ? od_rd[p] : ev_rd[p];
      rd_w1[p] = rd_a[p][0] ? ev_rd[p] : od_rd[p];
    end
  end

  // Collision: any shared word across the 1- or 2-word footprints of both
  // write ports; saturating count of such cycles.
  always_comb begin
    collide = wr_req[0].en & wr_req[1].en &
              ((wr_a[0] == wr_a[1]) |
               (wr_req[1].x2_en & (wr_a[0] == wr_b[1])) |
               (wr_req[0].x2_en & (wr_b[0] == wr_a[1])) |
               (wr_req[0].x2_en & wr_req[1].x2_en & (wr_b[0] == wr_b[1])));
    collision_cnt_d = collision_cnt_q;
    if (collide && (collision_cnt_q != {CNT_W{1'b1}})) collision_cnt_d = collision_cnt_q + 1'b1;
  end

  ex_bus_mem_bank #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_even (
    .clk_i       (i_clk),
    .rd_0_idx_i  (ev_rd_idx[0]), .rd_1_idx_i (ev_rd_idx[1]),
    .rd_0_data_o (ev_rd[0]),     .rd_1_data_o(ev_rd[1]),
    .wr_0_en_i   (ev_we[0]),     .wr_0_idx_i (ev_wr_idx[0]), .wr_0_data_i(ev_wd[0]),
    .wr_1_en_i   (ev_we[1]),     .wr_1_idx_i (ev_wr_idx[1]), .wr_1_data_i(ev_wd[1])
  );

  ex_bus_mem_bank #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_odd (
    .clk_i       (i_clk),
    .rd_0_idx_i  (od_rd_idx[0]), .rd_1_idx_i (od_rd_idx[1]),
    .rd_0_data_o (od_rd[0]),     .rd_1_data_o(od_rd[1]),
    .wr_0_en_i   (od_we[0]),     .wr_0_idx_i (od_wr_idx[0]), .wr_0_data_i(od_wd[0]),
    .wr_1_en_i   (od_we[1]),     .wr_1_idx_i (od_wr_idx[1]), .wr_1_data_i(od_wd[1])
  );

  // Read output registers, collision pulse and counter; reads hold when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_0_data_q     <= '0;
      rd_0_data_x2_q  <= '0;
      rd_1_data_q     <= '0;
      rd_1_data_x2_q  <= '0;
      wr_collision_q  <= 1'b0;
      collision_cnt_q <= '0;
    end else begin
      if (rd_req[0].en)                   rd_0_data_q    <= rd_w0[0];
      if (rd_req[0].en && rd_req[0].x2_en) rd_0_data_x2_q <= rd_w1[0];
      if (rd_req[1].en)                   rd_1_data_q    <= rd_w0[1];
      if (rd_req[1].en && rd_req[1].x2_en) rd_1_data_x2_q <= rd_w1[1];
      wr_collision_q  <= collide;
      collision_cnt_q <= collision_cnt_d;
    end
  end

  assign o_rd_0_data     = rd_0_data_q;
  assign o_rd_0_data_x2  = rd_0_data_x2_q;
  assign o_rd_1_data     = rd_1_data_q;
  assign o_rd_1_data_x2  = rd_1_data_x2_q;
  assign o_wr_collision  = wr_collision_q;
  assign o_collision_cnt = collision_cnt_q;

endmodule

// File: doc/ex_bus_mem_responder.md
Name: ex_bus_mem_responder

Overview:
- Data-memory responder sitting at the far end of the core's ex_bus.
- Serves two read ports and two write ports, each with an optional double-word ("x2") access.
- Replaces the simulation-side memory model with synthesizable RTL for FPGA prototyping and RTL co-simulation.
- Fixed latency, no back-pressure; the core never stalls on this interface.

Parameters:
- ADDR_W, 15, ex_bus word-address width.
- DATA_W, 64, width of one memory word.
- DEPTH_LOG2, 12, log2 of implemented words; address bits above this are ignored (modulo wrap).
- CNT_W, 16, width of the write-collision counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rd_0_addr  in  ADDR_W  read port 0 word address.
- i_rd_0_en  in  1  read port 0 request.
- i_rd_0_x2_en  in  1  read port 0 also reads addr+1.
- i_rd_1_addr / i_rd_1_en / i_rd_1_x2_en  in  ADDR_W/1/1  read port 1, same meaning.
- i_wr_0_addr  in  ADDR_W  write port 0 word address.
- i_wr_0_en  in  1  write port 0 request.
- i_wr_0_x2_en  in  1  write port 0 also writes addr+1.
- i_wr_0_data  in  DATA_W  word for addr.
- i_wr_0_data_x2  in  DATA_W  word for addr+1.
- i_wr_1_addr / i_wr_1_en / i_wr_1_x2_en / i_wr_1_data / i_wr_1_data_x2  in  ADDR_W/1/1/DATA_W/DATA_W  write port 1, same meaning.
- o_rd_0_data  out  DATA_W  read port 0 word at addr.
- o_rd_0_data_x2  out  DATA_W  read port 0 word at addr+1.
- o_rd_1_data / o_rd_1_data_x2  out  DATA_W  read port 1, same meaning.
- o_wr_collision  out  1  one-cycle pulse when both write ports hit a common word.
- o_collision_cnt  out  CNT_W  saturating count of collision cycles.

Behaviour:
- Single clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values:
  - all o_rd_* data = 0;
  - o_wr_collision = 0;
  - o_collision_cnt = 0.
  - Memory contents are not reset.
- Effective address = addr[DEPTH_LOG2-1:0]. The x2 word is (eff+1) mod 2^DEPTH_LOG2, so the top word wraps to word 0.
- Read latency is exactly 1 cycle. Inputs sampled at edge N appear on o_rd_* after edge N and are valid during cycle N+1.
- Read data registers load only when the port's en=1; otherwise they hold their last value.
- o_rd_*_data_x2 loads only when en=1 and x2_en=1; otherwise it holds.
- x2_en with en=0 is ignored (no read, no write).
- Writes commit at the clock edge when en=1. The x2 word is written only if x2_en=1.
- Read/write to the same word in the same cycle is read-first: the read returns the pre-write contents. New data is visible on a read issued in the following cycle.
- Write/write collision, evaluated over the full footprint of each port (1 or 2 words):
  - on any shared word, write port 1's data wins;
  - non-overlapping words from both ports are still written;
  - o_wr_collision pulses high the cycle after the colliding edge.
- o_collision_cnt increments once per colliding cycle and saturates at 2^CNT_W-1.
- Both read ports may target the same or overlapping words; no conflict arises.
- A single port's own x2 footprint is two distinct words; no self-conflict.
- Reset asserted mid-operation:
  - outputs clear immediately (asynchronously);
  - writes sampled on the edge coincident with or during reset are dropped;
  - memory keeps its contents.
- There is no FSM. The only sequential state is the storage, the four read registers, the collision pulse register and the counter.

Decomposition:
- Package ex_bus_pkg holds:
  - ADDR_W/DATA_W defaults;
  - the eff-address and wrap (next-address) function;
  - a typedef for one port request (addr, en, x2_en).
- Storage split into even/odd banks so an x2 access touches one word in each bank.
- Sub-module ex_bus_mem_bank is one bank: 2^(DEPTH_LOG2-1) words, 2 read ports, 2 write ports, port-1-wins priority, read-first.
- The top level contains:
  - bank select and address steering, including odd-start x2, where addr is in the odd bank and addr+1 is in the even bank at index+1;
  - the read output registers;
  - collision detection and the counter.

Test Plan:
- Single-word write/read: wr_0 addr 0x0010 data 0x1122334455667788; next cycle rd_0 addr 0x0010 -> o_rd_0_data = 0x1122334455667788 one cycle after the read.
- Odd-address x2 with wrap: DEPTH_LOG2=12, wr_1 addr 0x0FFF x2, data A/B; then rd_1 addr 0x0FFF x2 -> data=A, data_x2=B; rd_0 addr 0x0000 -> B; rd_0 addr 0x1FFF -> A (alias).
- Read-first: word 0x20 holds 0xAAAA; same cycle wr_0 0x20=0xBBBB and rd_0 0x20 -> returns 0xAAAA; rd_0 0x20 next cycle -> 0xBBBB.
- Write collision: wr_0 addr 0x40 x2 (C0,C1) and wr_1 addr 0x41 (D) in the same cycle -> 0x40=C0, 0x41=D, o_wr_collision=1 for one cycle, cnt=1.
- Hold and reset: rd_0 0x10 then en=0 for 5 cycles -> data held; assert i_rst_n=0 mid-stream -> all outputs 0 immediately; after release, read 0x10 -> original data intact.
- Counter saturation: CNT_W=4, 20 consecutive colliding cycles -> o_collision_cnt stops at 15.
